// File: rtl/bsw_job_scheduler.sv
// bsw_job_scheduler: round-robin front end that shares one banded
// Smith-Waterman accelerator between N_REQ requesters. A job is granted,
// its operands are latched and held for the whole run, the accelerator is
// started, its ready is awaited, and the aligned strings are handed back
// with a one-cycle done pulse to the owner.
//
// Optional build macro: BSW_TIMEOUT_EN
//   When defined, a RUN-state watchdog aborts a job after TIMEOUT cycles
//   and reports it through res_err. When undefined, RUN waits forever and
//   res_err is tied low.

module bsw_job_scheduler #(
    parameter int N_REQ        = 4,
    parameter int L            = 8,
    parameter int START_CYCLES = 2,
    parameter int TIMEOUT      = 1023
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*3*L-1:0]   req_R,
    input  logic [N_REQ*3*L-1:0]   req_Q,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       done,
    output logic [3*L+5:0]         res_R,
    output logic [3*L+5:0]         res_Q,
    output logic                   res_err,
    output logic                   busy,
    output logic                   acc_start,
    output logic [3*L-1:0]         acc_R,
    output logic [3*L-1:0]         acc_Q,
    input  logic [3*L+5:0]         acc_R_aligned,
    input  logic [3*L+5:0]         acc_Q_aligned,
    input  logic                   acc_ready
);

    localparam int W     = 3 * L;
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   owner;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   cand_idx;
    logic               win_valid;
    logic [7:0]         start_cnt;
    logic               start_last;
    logic               armed;
    logic               ready_hit;
    logic               timeout_hit;
    int                 cand;

`ifdef BSW_TIMEOUT_EN
    logic [15:0]        to_cnt;

    // Watchdog fires on the edge that completes the TIMEOUT-th RUN cycle
    assign timeout_hit = (state == RUN) && (to_cnt == 16'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
    assign res_err     = 1'b0;
`endif

    assign start_last = (start_cnt == 8'(START_CYCLES - 1));
    assign ready_hit  = armed && acc_ready;
    assign busy       = (state != IDLE);
    assign done       = (state == RESP) ? grant : '0;

    // Round-robin search: first requester above the pointer, wrapping around
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand     = (int'(ptr) + i) % N_REQ;
            cand_idx = cand[PTR_W-1:0];
            if (!win_valid && req[cand_idx]) begin
                win_valid = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // Next-state selection for the job sequence IDLE->START->RUN->RESP
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (win_valid) next_state = START;
            START:   if (start_last) next_state = RUN;
            RUN:     if (ready_hit || timeout_hit) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Job datapath: grant/operand latch, start pulse, arming and result capture
    always_ff @(posedge clk) begin
        if (reset) begin
            grant     <= '0;
            owner     <= '0;
            ptr       <= PTR_W'(N_REQ - 1);
            acc_start <= 1'b0;
            acc_R     <= '0;
            acc_Q     <= '0;
            start_cnt <= '0;
            armed     <= 1'b0;
            res_R     <= '0;
            res_Q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        grant          <= '0;
                        grant[win_idx] <= 1'b1;
                        owner          <= win_idx;
                        acc_R          <= req_R[win_idx*W +: W];
                        acc_Q          <= req_Q[win_idx*W +: W];
                        acc_start      <= 1'b1;
                        start_cnt      <= '0;
                    end
                end
                START: begin
                    if (start_last) begin
                        acc_start <= 1'b0;
                        armed     <= 1'b0;
                    end else begin
                        start_cnt <= start_cnt + 8'd1;
                    end
                end
                RUN: begin
                    if (ready_hit) begin
                        res_R <= acc_R_aligned;
                        res_Q <= acc_Q_aligned;
                    end else if (timeout_hit) begin
                        res_R <= '0;
                        res_Q <= '0;
                    end else if (!acc_ready) begin
                        armed <= 1'b1;
                    end
                end
                RESP: begin
                    grant <= '0;
                    ptr   <= owner;
                end
                default: ;
            endcase
        end
    end

`ifdef BSW_TIMEOUT_EN
    // RUN cycle counter and abort flag; a same-edge ready takes priority
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt  <= '0;
            res_err <= 1'b0;
        end else begin
            if (state == START && start_last) to_cnt <= '0;
            else if (state == RUN)            to_cnt <= to_cnt + 16'd1;
            if (state == RUN) begin
                if (ready_hit)        res_err <= 1'b0;
                else if (timeout_hit) res_err <= 1'b1;
            end
        end
    end
`endif

endmodule
